rom_stream_reader: RTL
======================

# rom_stream_reader

Boot-time ROM streaming engine that sits directly upstream of the parallel boot ROM. It drives the ROM's address, chip-enable and output-enable. It reads a contiguous byte range with a programmable number of wait cycles per access, and presents each byte on a valid/ready stream to the downstream consumer, typically the shadow-RAM loader.

## Interface
Parameters:
- AWID, 18, ROM address width
- DWID, 8, ROM data width
- WAIT_W, 4, width of the wait-cycle setting

Ports:
- clk  input  1  single system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE from any state
- base_addr  input  AWID  first ROM address; captured on accepted start
- length  input  AWID+1  byte count, 0..2**AWID; captured on accepted start
- wait_cyc  input  WAIT_W  extra access cycles; captured on accepted start
- rom_addr  output  AWID  ROM address, registered
- rom_ce_n  output  1  ROM chip enable, active low, registered
- rom_oe_n  output  1  ROM output enable, active low, registered
- rom_data  input  DWID  ROM data bus; Z when ROM deselected
- out_data  output  DWID  latched byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts byte
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse on transfer completion

## Operation
- Reset values:
  - rom_ce_n=1, rom_oe_n=1, rom_addr=0
  - out_data=0, out_valid=0, busy=0, done=0
  - state IDLE
- State IDLE:
  - ROM deselected.
  - start=1 captures base_addr, length and wait_cyc.
  - If captured length=0: pulse done next cycle, remain IDLE, ROM never selected.
  - Otherwise go to ACCESS with wait counter = wait_cyc.
- State ACCESS:
  - rom_ce_n=rom_oe_n=0 and rom_addr = current address.
  - If counter≠0, decrement it.
  - If counter=0: latch rom_data into out_data, deselect the ROM, go to OUTPUT.
  - Each access therefore selects the ROM for exactly wait_cyc+1 cycles.
- State OUTPUT:
  - out_valid=1 and out_data stable.
  - On out_ready=1 (handshake): address increments modulo 2**AWID (0x3FFFF wraps to 0x00000) and remaining count decrements.
  - If this was the last byte: go to IDLE, pulse done.
  - Otherwise go to ACCESS with counter reloaded from captured wait_cyc.
- busy=1 in ACCESS and OUTPUT, 0 in IDLE.
- start while busy is ignored and does not alter captured values.
- abort=1 has priority over every other event:
  - Next state is IDLE, ROM deselected, out_valid=0.
  - No done pulse; any pending byte is discarded.
  - abort and start in the same IDLE cycle: abort wins, start is dropped.
- Input changes to base_addr/length/wait_cyc mid-transfer have no effect.
- Async rst mid-transfer: all outputs immediately return to their reset values; no done.

## Timing
- Start accepted at edge N:
  - ROM selected from edge N through edge N+wait_cyc+1.
  - rom_data sampled at edge N+wait_cyc+1.
  - out_valid high from edge N+wait_cyc+1.
- With out_ready held high, out_valid is high for one cycle; the next ROM select begins at the handshake edge.
- Throughput: one byte per wait_cyc+2 cycles.
- done is high for the single cycle following the last handshake edge; busy falls on that same edge.
- A new start is accepted while done is high (state is IDLE).
- rom_addr is held stable for the entire select window; it changes only when the ROM is deselected.

## Test plan
- Reset, then base=0x00100, length=4, wait_cyc=2, out_ready=1 → bytes mem[0x100..0x103] in order, each ROM select 3 cycles, out_valid every 4 cycles, done 1 cycle after 4th handshake.
- length=0 start → done pulses next cycle, rom_ce_n never low, out_valid never high.
- base=0x3FFFE, length=4, wait_cyc=0 → addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; 2 cycles per byte.
- out_ready low for 5 cycles at 2nd byte → out_valid and out_data held, ROM deselected, no address advance; resumes on out_ready.
- abort asserted during ACCESS of 3rd byte of 8 → IDLE next cycle, ce_n/oe_n=1, no done; a following start re-reads from the new base.
- rst asserted mid-OUTPUT → outputs at reset values without a clock edge; start during busy otherwise ignored (captured length unchanged).

Source files
------------

// File: rtl/rom_stream_reader.sv
// Streams a contiguous byte range out of a parallel boot ROM onto a
// valid/ready interface, with a programmable number of wait cycles per access.
module rom_stream_reader #(
  parameter int AWID   = 18,
  parameter int DWID   = 8,
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [AWID-1:0]   base_addr,
  input  logic [AWID:0]     length,
  input  logic [WAIT_W-1:0] wait_cyc,
  output logic [AWID-1:0]   rom_addr,
  output logic              rom_ce_n,
  output logic              rom_oe_n,
  input  logic [DWID-1:0]   rom_data,
  output logic [DWID-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    OUTPUT
  } state_t;

  state_t            state_q, state_d;
  logic [AWID-1:0]   addr_q, addr_d;
  logic [AWID:0]     rem_q, rem_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [DWID-1:0]   data_q, data_d;
  logic              done_q, done_d;
  logic              sel_n_q, sel_n_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_d = base_addr;
            rem_d  = length;
            wait_d = wait_cyc;
            cnt_d  = wait_cyc;
            if (length == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            data_d  = rom_data;
            state_d = OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            if (rem_q == 1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ACCESS;
              cnt_d   = wait_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Bus-facing outputs are registered straight from the next state
    sel_n_d = (state_d != ACCESS);
    valid_d = (state_d == OUTPUT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      sel_n_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      sel_n_q <= sel_n_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign rom_addr  = addr_q;
  assign rom_ce_n  = sel_n_q;
  assign rom_oe_n  = sel_n_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
